// File: rtl/io_pkg.sv
// Shared types for the CPU IO responder: FSM states, syscall codes and default word width.
package io_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_RD = 2'd1,
    WAIT_WR = 2'd2,
    ACK     = 2'd3
  } io_state_e;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } syscall_e;

  // The request that owns the current transaction, selected by its recorded type.
  function automatic logic req_active(input logic is_rd, input logic rd, input logic wr);
    return is_rd ? rd : wr;
  endfunction

endpackage

// File: rtl/io_responder_if.sv
// CPU IO handshake plus host streaming signals for io_responder.
// Optional protocol monitor ports appear when IO_RESPONDER_PROTO_ERR_EN is defined.
interface io_responder_if import io_pkg::*; #(parameter int WIDTH = WORD_W);

  logic             io_read;
  logic             io_write;
  logic [WIDTH-1:0] io_wdata;
  logic [WIDTH-1:0] io_rdata;
  logic             ioack;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef IO_RESPONDER_PROTO_ERR_EN
  logic             proto_err;
  logic [15:0]      xfer_count;
`endif

  modport master (
    output io_read, io_write, io_wdata, in_valid, in_data, out_ready,
`ifdef IO_RESPONDER_PROTO_ERR_EN
    input  proto_err, xfer_count,
`endif
    input  io_rdata, ioack, in_ready, out_valid, out_data
  );

  modport slave (
    input  io_read, io_write, io_wdata, in_valid, in_data, out_ready,
`ifdef IO_RESPONDER_PROTO_ERR_EN
    output proto_err, xfer_count,
`endif
    output io_rdata, ioack, in_ready, out_valid, out_data
  );

endinterface

// File: rtl/io_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push ignored when full, pop ignored when empty.
module io_fifo import io_pkg::*; #(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             full_s;
  logic             empty_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign full    = full_s;
  assign empty   = empty_s;
  assign head    = mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointer update; a push and a pop in the same cycle are both honoured.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push && !full_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end
      if (pop && !empty_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/io_responder.sv
// Device-side responder for the four-phase io_read/io_write/ioack handshake.
// Optional protocol monitor (proto_err, xfer_count) enabled by IO_RESPONDER_PROTO_ERR_EN.
module io_responder import io_pkg::*; #(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4
) (
  input logic           clock,
  input logic           reset,
  io_responder_if.slave bus
);

  io_state_e        state_r;
  io_state_e        state_next_s;
  logic             is_rd_r;
  logic             ioack_r;
  logic [WIDTH-1:0] rdata_r;
  logic             in_pop_s;
  logic             out_push_s;
  logic             active_req_s;
  logic             in_full_s;
  logic             in_empty_s;
  logic             out_full_s;
  logic             out_empty_s;
  logic [WIDTH-1:0] in_head_s;
  logic [WIDTH-1:0] out_head_s;

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clock(clock), .reset(reset), .push(bus.in_valid), .pop(in_pop_s),
    .wdata(bus.in_data), .full(in_full_s), .empty(in_empty_s), .head(in_head_s)
  );

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clock(clock), .reset(reset), .push(out_push_s), .pop(bus.out_ready),
    .wdata(bus.io_wdata), .full(out_full_s), .empty(out_empty_s), .head(out_head_s)
  );

  assign active_req_s  = req_active(is_rd_r, bus.io_read, bus.io_write);
  assign bus.ioack     = ioack_r;
  assign bus.io_rdata  = rdata_r;
  assign bus.in_ready  = !in_full_s;
  assign bus.out_valid = !out_empty_s;
  assign bus.out_data  = out_head_s;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; read wins when both requests arrive together.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.io_read) begin
          state_next_s = in_empty_s ? WAIT_RD : ACK;
        end else if (bus.io_write) begin
          state_next_s = out_full_s ? WAIT_WR : ACK;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT_RD: begin
        if (!bus.io_read) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = in_empty_s ? WAIT_RD : ACK;
        end
      end
      WAIT_WR: begin
        if (!bus.io_write) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = out_full_s ? WAIT_WR : ACK;
        end
      end
      ACK:     state_next_s = active_req_s ? ACK : IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FIFO strobes: exactly one pop or push per accepted transaction.
  always_comb begin
    in_pop_s   = 1'b0;
    out_push_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.io_read) begin
          in_pop_s = !in_empty_s;
        end else begin
          out_push_s = bus.io_write && !out_full_s;
        end
      end
      WAIT_RD: in_pop_s   = bus.io_read && !in_empty_s;
      WAIT_WR: out_push_s = bus.io_write && !out_full_s;
      ACK:     in_pop_s   = 1'b0;
      default: out_push_s = 1'b0;
    endcase
  end

  // Registered handshake outputs; io_rdata only moves when a word is popped.
  always_ff @(posedge clock) begin
    if (reset) begin
      ioack_r <= 1'b0;
      rdata_r <= {WIDTH{1'b0}};
      is_rd_r <= 1'b0;
    end else begin
      ioack_r <= (state_next_s == ACK);
      if (in_pop_s) begin
        rdata_r <= in_head_s;
        is_rd_r <= 1'b1;
      end else if (out_push_s) begin
        is_rd_r <= 1'b0;
      end else begin
        is_rd_r <= is_rd_r;
      end
    end
  end

`ifdef IO_RESPONDER_PROTO_ERR_EN
  logic        proto_err_r;
  logic [15:0] xfer_count_r;
  logic        err_event_s;

  // Protocol violation detector.
  always_comb begin
    err_event_s = 1'b0;
    case (state_r)
      IDLE:    err_event_s = bus.io_read && bus.io_write;
      WAIT_RD: err_event_s = !bus.io_read;
      WAIT_WR: err_event_s = !bus.io_write;
      ACK:     err_event_s = (is_rd_r && bus.io_write) || (!is_rd_r && bus.io_read);
      default: err_event_s = 1'b0;
    endcase
  end

  // Sticky error flag and completed-transaction counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      proto_err_r  <= 1'b0;
      xfer_count_r <= 16'd0;
    end else begin
      proto_err_r <= proto_err_r | err_event_s;
      if (state_r == ACK && state_next_s == IDLE) begin
        xfer_count_r <= xfer_count_r + 16'd1;
      end else begin
        xfer_count_r <= xfer_count_r;
      end
    end
  end

  assign bus.proto_err  = proto_err_r;
  assign bus.xfer_count = xfer_count_r;
`else
  // Plain responder: no protocol monitor outputs in this build.
`endif

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: directed handshake sequences, a vector table
// for output-FIFO backpressure, and randomized traffic against a queue-based model.
module tb_io_responder;
  import io_pkg::*;

  localparam int W = 16;
  localparam int D = 4;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  logic [W-1:0] in_q[$];
  logic [W-1:0] out_q[$];

  io_responder_if #(.WIDTH(W)) bus ();
  io_responder #(.WIDTH(W), .DEPTH(D)) dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         wr;
    logic [W-1:0] wdata;
    logic         out_ready;
    logic         exp_ack;
    logic         exp_ov;
    logic [W-1:0] exp_od;
  } wvec_t;

  wvec_t wtab[17];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    in_q.delete();
    out_q.delete();
  endtask

  task automatic host_push(input logic [W-1:0] d);
    logic ok;
    ok = (in_q.size() < D);
    check("in_ready", bus.in_ready, ok);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
    if (ok) in_q.push_back(d);
  endtask

  task automatic host_pop();
    logic v;
    v = (out_q.size() > 0);
    check("out_valid", bus.out_valid, v);
    if (v) check("out_data", bus.out_data, out_q[0]);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    if (v) void'(out_q.pop_front());
  endtask

  task automatic cpu_read();
    logic [W-1:0] e;
    e = in_q.pop_front();
    bus.io_read = 1'b1;
    tick();
    check("rd_ack", bus.ioack, 1'b1);
    check("rd_data", bus.io_rdata, e);
    tick();
    check("rd_hold_ack", bus.ioack, 1'b1);
    check("rd_hold_data", bus.io_rdata, e);
    bus.io_read = 1'b0;
    tick();
    check("rd_release", bus.ioack, 1'b0);
  endtask

  task automatic cpu_write(input logic [W-1:0] d);
    bus.io_write = 1'b1;
    bus.io_wdata = d;
    tick();
    check("wr_ack", bus.ioack, 1'b1);
    bus.io_write = 1'b0;
    tick();
    check("wr_release", bus.ioack, 1'b0);
    out_q.push_back(d);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.io_read = 1'b0;
    bus.io_write = 1'b0;
    bus.io_wdata = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;

    // wr, wdata, out_ready, exp ioack, exp out_valid, exp out_data
    wtab[0]  = '{1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0001};
    wtab[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001};
    wtab[2]  = '{1'b1, 16'h0002, 1'b0, 1'b1, 1'b1, 16'h0001};
    wtab[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001};
    wtab[4]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, 16'h0001};
    wtab[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001};
    wtab[6]  = '{1'b1, 16'h0004, 1'b0, 1'b1, 1'b1, 16'h0001};
    wtab[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001};
    wtab[8]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0001};
    wtab[9]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0001};
    wtab[10] = '{1'b1, 16'h0005, 1'b1, 1'b0, 1'b1, 16'h0002};
    wtab[11] = '{1'b1, 16'h0005, 1'b0, 1'b1, 1'b1, 16'h0002};
    wtab[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0002};
    wtab[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0003};
    wtab[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0004};
    wtab[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0005};
    wtab[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};

    do_reset();
    check("rst_ack", bus.ioack, 1'b0);
    check("rst_rdata", bus.io_rdata, 16'h0000);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 16'h0000);

    // Basic load: one-cycle ack latency, hold while requested, release next cycle.
    host_push(16'h1234);
    repeat (5) tick();
    cpu_read();
    check("t1_in_ready", bus.in_ready, 1'b1);

    // Load from an empty FIFO stalls until the host supplies a word.
    bus.io_read = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t2_stall", bus.ioack, 1'b0);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hBEEF;
    tick();
    bus.in_valid = 1'b0;
    check("t2_c1", bus.ioack, 1'b0);
    tick();
    check("t2_c2_ack", bus.ioack, 1'b1);
    check("t2_c2_data", bus.io_rdata, 16'hBEEF);
    bus.io_read = 1'b0;
    tick();
    check("t2_release", bus.ioack, 1'b0);

    // Output FIFO fill, backpressure on the fifth store, ordered drain.
    for (int i = 0; i < 17; i++) begin
      bus.io_write  = wtab[i].wr;
      bus.io_wdata  = wtab[i].wdata;
      bus.out_ready = wtab[i].out_ready;
      tick();
      check("wtab_ack", bus.ioack, wtab[i].exp_ack);
      check("wtab_out_valid", bus.out_valid, wtab[i].exp_ov);
      if (wtab[i].exp_ov) check("wtab_out_data", bus.out_data, wtab[i].exp_od);
    end
    bus.io_write  = 1'b0;
    bus.out_ready = 1'b0;

    // Host offers a word into a full input FIFO in the same cycle the CPU pops.
    for (int i = 0; i < D; i++) host_push(16'hA000 + 16'(i));
    check("t4_full", bus.in_ready, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hA004;
    bus.io_read  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("t4_ack", bus.ioack, 1'b1);
    check("t4_data", bus.io_rdata, in_q.pop_front());
    check("t4_ready", bus.in_ready, 1'b1);
    bus.io_read = 1'b0;
    tick();
    check("t4_release", bus.ioack, 1'b0);
    host_push(16'hA004);
    for (int i = 0; i < D; i++) cpu_read();
    check("t4_drained", bus.in_ready, 1'b1);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0: host_push(16'($urandom));
        1: host_pop();
        2: if (in_q.size() > 0) cpu_read(); else host_push(16'($urandom));
        default: if (out_q.size() < D) cpu_write(16'($urandom)); else host_pop();
      endcase
    end

    // Reset in the middle of an acknowledged read.
    cpu_write(16'h00C3);
    host_push(16'h0C3C);
    bus.io_read = 1'b1;
    tick();
    check("t5_ack", bus.ioack, 1'b1);
    reset = 1'b1;
    tick();
    check("t5_ack_clr", bus.ioack, 1'b0);
    check("t5_rdata", bus.io_rdata, 16'h0000);
    check("t5_in_ready", bus.in_ready, 1'b1);
    check("t5_out_valid", bus.out_valid, 1'b0);
    reset = 1'b0;
    in_q.delete();
    out_q.delete();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_wait_rd", bus.ioack, 1'b0);
    end
    bus.io_read = 1'b0;
    tick();
    check("t5_idle", bus.ioack, 1'b0);

`ifdef IO_RESPONDER_PROTO_ERR_EN
    do_reset();
    check("pe_rst", bus.proto_err, 1'b0);
    check("xc_rst", bus.xfer_count, 16'd0);
    host_push(16'h00AA);
    bus.io_read  = 1'b1;
    bus.io_write = 1'b1;
    bus.io_wdata = 16'h7777;
    tick();
    check("pe_ack", bus.ioack, 1'b1);
    check("pe_rdata", bus.io_rdata, in_q.pop_front());
    check("pe_no_push", bus.out_valid, 1'b0);
    bus.io_read  = 1'b0;
    bus.io_write = 1'b0;
    tick();
    check("pe_release", bus.ioack, 1'b0);
    check("pe_set", bus.proto_err, 1'b1);
    cpu_write(16'h0011);
    cpu_write(16'h0022);
    host_push(16'h0033);
    cpu_read();
    check("xc_count", bus.xfer_count, 16'd4);
    check("pe_sticky", bus.proto_err, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
